// File: rtl/SystemPeripheral_Pkg.sv
// rtl/SystemPeripheral_Pkg.sv - shared widths, bus structs and arbiter FSM state for the system peripheral bus
// Contents:
//   SP_ADDR_LEN / SP_ID_LEN / SP_OFFSET_LEN  address split: [ID | offset]
//   sys_peripheral_t   raddr/waddr/wdata bundle broadcast to all peripherals
//   sp_master_req_t    latched master transaction (we, addr, wdata)
//   sp_arb_state_e     arbiter FSM states
//   sp_addr_id / sp_addr_offset  address field extractors
package SystemPeripheral_Pkg;

    localparam int SP_ADDR_LEN    = 5;
    localparam int SP_ID_LEN      = 3;
    localparam int SP_OFFSET_LEN  = SP_ADDR_LEN - SP_ID_LEN;
    localparam int SP_DATA_LEN    = 32;
    localparam int SP_NUM_PERIPH  = 1 << SP_ID_LEN;
    localparam int SP_NUM_MASTERS = 2;

    typedef struct packed {
        logic [SP_OFFSET_LEN-1:0] raddr;
        logic [SP_OFFSET_LEN-1:0] waddr;
        logic [SP_DATA_LEN-1:0]   wdata;
    } sys_peripheral_t;

    typedef struct packed {
        logic                   we;
        logic [SP_ADDR_LEN-1:0] addr;
        logic [SP_DATA_LEN-1:0] wdata;
    } sp_master_req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        RWAIT = 2'd2
    } sp_arb_state_e;

    function automatic logic [SP_ID_LEN-1:0] sp_addr_id(input logic [SP_ADDR_LEN-1:0] addr);
        return addr[SP_ADDR_LEN-1:SP_OFFSET_LEN];
    endfunction

    function automatic logic [SP_OFFSET_LEN-1:0] sp_addr_offset(input logic [SP_ADDR_LEN-1:0] addr);
        return addr[SP_OFFSET_LEN-1:0];
    endfunction

endpackage

// File: rtl/sp_rr_arb2.sv
// rtl/sp_rr_arb2.sv - two-requester round-robin arbiter
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   req[1:0]     request vector
//   advance      commit the current grant (updates last_grant)
//   grant[1:0]   one-hot grant (combinational, zero when no request)
//   last_grant   index of the most recently committed grant; resets to 1
module sp_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       last_grant
);

    logic last_grant_q, last_grant_d;

    always_comb begin
        grant        = req;
        last_grant_d = last_grant_q;
        // On a tie the requester that did not win last time takes the grant.
        if (req == 2'b11) begin
            grant = last_grant_q ? 2'b01 : 2'b10;
        end
        if (advance && (req != 2'b00)) begin
            last_grant_d = grant[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant = last_grant_q;

endmodule

// File: rtl/sp_bus_arbiter.sv
// rtl/sp_bus_arbiter.sv - two-master arbiter onto the system peripheral bus, one transaction outstanding
// Parameters:
//   READ_LATENCY  cycles from the read strobe until m_ready on a read (1..3)
//   PERIPH_MASK   bit i set means peripheral ID i is mapped
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   m_req/m_we        per-master request and write enable (bit 0 core bridge, bit 1 debug port)
//   m_addr/m_wdata    per-master address ([4:2] ID, [1:0] offset) and write data
//   m_ready           one-cycle completion pulse to the granted master
//   m_rdata           shared read data, valid with m_ready on a read, held otherwise
//   sp                raddr/waddr/wdata broadcast to peripherals
//   sp_rd_sel/wr_sel  one-hot read/write strobes per peripheral ID
//   sp_rdata          per-peripheral read data indexed by ID
module sp_bus_arbiter
    import SystemPeripheral_Pkg::*;
#(
    parameter int                       READ_LATENCY = 1,
    parameter logic [SP_NUM_PERIPH-1:0] PERIPH_MASK  = 8'hFF
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [SP_NUM_MASTERS-1:0]                        m_req,
    input  logic [SP_NUM_MASTERS-1:0]                        m_we,
    input  logic [SP_NUM_MASTERS-1:0][SP_ADDR_LEN-1:0]       m_addr,
    input  logic [SP_NUM_MASTERS-1:0][SP_DATA_LEN-1:0]       m_wdata,
    output logic [SP_NUM_MASTERS-1:0]                        m_ready,
    output logic [SP_DATA_LEN-1:0]                           m_rdata,
    output sys_peripheral_t                                  sp,
    output logic [SP_NUM_PERIPH-1:0]                         sp_rd_sel,
    output logic [SP_NUM_PERIPH-1:0]                         sp_wr_sel,
    input  logic [SP_NUM_PERIPH-1:0][SP_DATA_LEN-1:0]        sp_rdata
);

    localparam logic [1:0] RL = 2'(READ_LATENCY);

    sp_arb_state_e            state_q, state_d;
    sp_master_req_t           req_q, req_d;
    logic [1:0]               cnt_q, cnt_d;
    logic [SP_DATA_LEN-1:0]   rdata_q, rdata_d;
    logic [1:0]               grant;
    logic                     advance;
    logic                     cur_master;
    logic [SP_ID_LEN-1:0]     cur_id;
    logic                     id_mapped;

    assign advance = (state_q == IDLE) && (grant != 2'b00);

    // After a grant is committed, last_grant names the master that owns the
    // outstanding transaction, so it doubles as the m_ready index.
    sp_rr_arb2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .req        (m_req),
        .advance    (advance),
        .grant      (grant),
        .last_grant (cur_master)
    );

    assign cur_id    = sp_addr_id(req_q.addr);
    assign id_mapped = PERIPH_MASK[cur_id];

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        m_ready   = '0;
        sp_rd_sel = '0;
        sp_wr_sel = '0;

        case (state_q)
            IDLE: begin
                if (advance) begin
                    req_d.we    = m_we[grant[1]];
                    req_d.addr  = m_addr[grant[1]];
                    req_d.wdata = m_wdata[grant[1]];
                    state_d     = XFER;
                end
            end
            XFER: begin
                if (req_q.we) begin
                    sp_wr_sel[cur_id]   = id_mapped;
                    m_ready[cur_master] = 1'b1;
                    state_d             = IDLE;
                end else begin
                    sp_rd_sel[cur_id] = id_mapped;
                    cnt_d             = RL;
                    state_d           = RWAIT;
                end
            end
            RWAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    m_ready[cur_master] = 1'b1;
                    state_d             = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Read data is captured on the cycle the counter reaches 1 so it is
        // presented together with m_ready on the following cycle.
        if ((state_q != IDLE) && (cnt_d == 2'd1)) begin
            rdata_d = id_mapped ? sp_rdata[cur_id] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // The peripheral bundle is a view of the latched request, so it holds
    // until the next grant and clears with reset.
    always_comb begin
        sp       = '0;
        sp.raddr = sp_addr_offset(req_q.addr);
        sp.waddr = sp_addr_offset(req_q.addr);
        sp.wdata = req_q.wdata;
    end

    assign m_rdata = rdata_q;

endmodule
